vc_input_unit: RTL
==================

VC_INPUT_UNIT -- requirements
Module: vc_input_unit

Interface
REQ-001 Param DATA_W, default 35, flit width; IDATA[DATA_W-1]=head flag, IDATA[DATA_W-2]=tail flag, IDATA[2*COORD_W-1:0]={dst_y,dst_x} on head flits.
REQ-002 Param NUM_VC, default 2, virtual channels (range 1..8).
REQ-003 Param DEPTH, default 4, flits per VC buffer (power of two, >=2).
REQ-004 Param COORD_W, default 2, mesh coordinate width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 RST_  in  1  asynchronous active-low reset.
REQ-007 MY_XPOS / MY_YPOS  in  COORD_W each  this router's coordinates, quasi-static.
REQ-008 IDATA  in  DATA_W  incoming flit.
REQ-009 IVALID  in  1  flit present this cycle.
REQ-010 IVCH  in  max(1,clog2(NUM_VC))  target VC of incoming flit.
REQ-011 ORDY  out  NUM_VC  per-VC buffer not full.
REQ-012 OACK  out  NUM_VC  per-VC one-cycle accept pulse.
REQ-013 OLCK  out  NUM_VC  per-VC packet-in-progress lock.
REQ-014 ODATA  out  NUM_VC*DATA_W  head-of-buffer flit per VC, VC v in slice v.
REQ-015 OVALID  out  NUM_VC  per-VC buffer non-empty.
REQ-016 OPORT  out  NUM_VC*3  output port of each VC's head flit.
REQ-017 IRD  in  NUM_VC  per-VC pop strobe from switch allocator.
REQ-018 OERR  out  1  sticky overflow error.

Function
REQ-019 Write: flit enqueued into VC v=IVCH when IVALID=1 and ORDY[v]=1; IVCH>=NUM_VC, or ORDY[v]=0 -> flit dropped, OERR set to 1 next edge, held until reset.
REQ-020 ORDY[v] = (count[v] < DEPTH), driven from registered count, no combinational path from IVALID/IRD.
REQ-021 OACK[v] = 1 for exactly the cycle after each accepted write to v, else 0.
REQ-022 OVALID[v] = (count[v] != 0); ODATA/OPORT slice v valid only when OVALID[v]=1.
REQ-023 Pop: IRD[v]=1 with OVALID[v]=1 removes head flit at edge; IRD[v] with OVALID[v]=0 ignored, no state change.
REQ-024 Simultaneous write and pop on same VC: both take effect, count unchanged; on empty VC the written flit appears on ODATA next cycle (1-cycle latency, no bypass).
REQ-025 Route, XY order, computed at enqueue of head flit: dst_x>MY_XPOS ->1 (E); dst_x<MY_XPOS ->2 (W); else dst_y>MY_YPOS ->3 (S); dst_y<MY_YPOS ->4 (N); else 0 (local); unsigned compares.
REQ-026 Route stored with each flit; head flits store computed route and update per-VC cur_route; body/tail flits store cur_route[v]; a VC holding packet A's tail and packet B's head shows each flit's own route.
REQ-027 Lock FSM per VC, states IDLE/LOCKED: IDLE->LOCKED on accepted head write; LOCKED->IDLE on pop of a flit with tail flag; set and clear on same edge -> LOCKED.
REQ-028 Head+tail flit (single-flit packet): lock on write, release on its pop.
REQ-029 Read/write pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-030 RST_=0 asynchronously clears pointers, counts, cur_route, OACK, OLCK, OERR to 0; ORDY all 1, OVALID all 0; buffer contents not cleared.
REQ-031 Reset mid-packet discards buffered flits; locks released; first flit after reset accepted normally.

Structure
REQ-032 Shared package router_pkg holds port encodings (LOCAL=0,E=1,W=2,S=3,N=4), head/tail bit-position constants, flit typedef.
REQ-033 One sub-module vc_fifo (DATA_W+3 wide, DEPTH deep, count/full/empty outputs) instantiated NUM_VC times via generate.

Verification
REQ-034 Reset, MY=(1,1): write head dst(3,1) on VC0 -> OACK=01 next cycle, OVALID[0]=1, OPORT[0]=1, OLCK[0]=1.
REQ-035 4 flits to VC1 (DEPTH=4) with no IRD -> ORDY=01; 5th write -> dropped, no OACK, OERR=1.
REQ-036 VC0 has tail of pkt A (route 2) and head of pkt B dst(1,0); pop twice -> OPORT[0]=2 then 4; OLCK[0] stays 1.
REQ-037 VC0 full: IVALID+IRD[0] same cycle -> write rejected, pop taken, count 3, ORDY[0]=1 next cycle.
REQ-038 Head+tail flit dst(1,1) on VC1 -> OPORT=0, OLCK[1]=1; IRD[1] -> OLCK[1]=0, OVALID[1]=0.
REQ-039 RST_ low mid-packet with 3 flits buffered -> OVALID=00, OLCK=00, ORDY=11 immediately, before next clk edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: output port encodings, flit field positions,
// flit type, lock state and the XY routing helper.
package router_pkg;

  // Output port encodings
  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_E     = 3'd1;
  localparam logic [2:0] PORT_W     = 3'd2;
  localparam logic [2:0] PORT_S     = 3'd3;
  localparam logic [2:0] PORT_N     = 3'd4;
  localparam int         ROUTE_W    = 3;

  // Head/tail flags sit at DATA_W-HEAD_OFS and DATA_W-TAIL_OFS
  localparam int HEAD_OFS = 1;
  localparam int TAIL_OFS = 2;

  // Default flit shape
  localparam int FLIT_W = 35;
  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {LK_IDLE = 1'b0, LK_LOCKED = 1'b1} lock_e;

  // Dimension-ordered route: resolve X first, then Y, else eject locally.
  // Coordinates are zero-extended to 8 bits by the caller.
  function automatic logic [2:0] xy_route(input logic [7:0] dx, input logic [7:0] dy,
                                          input logic [7:0] mx, input logic [7:0] my);
    if (dx > mx)      return PORT_E;
    else if (dx < mx) return PORT_W;
    else if (dy > my) return PORT_S;
    else if (dy < my) return PORT_N;
    else              return PORT_LOCAL;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC flit buffer: power-of-two circular FIFO with registered count.
// Storage is not reset; only pointers and count are.
module vc_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_wr, do_rd;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rp_q];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Flit storage
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= wr_data;
  end

endmodule

// File: rtl/vc_input_unit.sv
// Router input unit: demuxes incoming flits into per-VC buffers, tags each
// flit with its XY output port and tracks per-VC packet locks.
module vc_input_unit
  import router_pkg::*;
#(
  parameter int DATA_W  = 35,
  parameter int NUM_VC  = 2,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 2,
  localparam int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                       clk,
  input  logic                       RST_,
  input  logic [COORD_W-1:0]         MY_XPOS,
  input  logic [COORD_W-1:0]         MY_YPOS,
  input  logic [DATA_W-1:0]          IDATA,
  input  logic                       IVALID,
  input  logic [VCW-1:0]             IVCH,
  output logic [NUM_VC-1:0]          ORDY,
  output logic [NUM_VC-1:0]          OACK,
  output logic [NUM_VC-1:0]          OLCK,
  output logic [NUM_VC*DATA_W-1:0]   ODATA,
  output logic [NUM_VC-1:0]          OVALID,
  output logic [NUM_VC*3-1:0]        OPORT,
  input  logic [NUM_VC-1:0]          IRD,
  output logic                       OERR
);
  localparam int FW = DATA_W + ROUTE_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [COORD_W-1:0] dst_x, dst_y;
  logic [2:0]         route_in;
  logic               head_in, vc_ok, reject;
  logic [NUM_VC-1:0]  full, empty;
  logic               oerr_q;

  assign head_in  = IDATA[DATA_W-HEAD_OFS];
  assign dst_x    = IDATA[COORD_W-1:0];
  assign dst_y    = IDATA[2*COORD_W-1:COORD_W];
  assign route_in = xy_route(8'(dst_x), 8'(dst_y), 8'(MY_XPOS), 8'(MY_YPOS));
  assign vc_ok    = (32'(IVCH) < 32'(NUM_VC));
  assign reject   = IVALID && (!vc_ok || full[IVCH]);
  assign OERR     = oerr_q;

  // Sticky error on any dropped flit
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_)       oerr_q <= 1'b0;
    else if (reject) oerr_q <= 1'b1;
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic          wr_en, rd_en, push_head, pop_head, pop_tail;
    logic [FW-1:0] wr_flit, rd_flit;
    logic [CW-1:0] cnt, heads_q, heads_d;
    logic [2:0]    cur_route_q;
    logic          oack_q;
    lock_e         lk_q;

    assign wr_en     = IVALID && vc_ok && (IVCH == VCW'(v)) && !full[v];
    assign rd_en     = IRD[v] && !empty[v];
    assign wr_flit   = {(head_in ? route_in : cur_route_q), IDATA};
    assign push_head = wr_en && head_in;
    assign pop_head  = rd_en && rd_flit[DATA_W-HEAD_OFS];
    assign pop_tail  = rd_en && rd_flit[DATA_W-TAIL_OFS];
    assign heads_d   = heads_q + CW'(push_head) - CW'(pop_head);

    vc_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (RST_),
      .wr_en   (wr_en),
      .wr_data (wr_flit),
      .rd_en   (rd_en),
      .rd_data (rd_flit),
      .count   (cnt),
      .full    (full[v]),
      .empty   (empty[v])
    );

    assign ORDY[v]                  = (cnt < CW'(DEPTH));
    assign OVALID[v]                = !empty[v];
    assign ODATA[v*DATA_W +: DATA_W] = rd_flit[DATA_W-1:0];
    assign OPORT[v*3 +: 3]          = rd_flit[DATA_W +: 3];
    assign OACK[v]                  = oack_q;
    assign OLCK[v]                  = (lk_q == LK_LOCKED);

    // Accept pulse, route of the packet in progress, buffered head count
    always_ff @(posedge clk or negedge RST_) begin
      if (!RST_) begin
        oack_q      <= 1'b0;
        cur_route_q <= PORT_LOCAL;
        heads_q     <= '0;
      end else begin
        oack_q  <= wr_en;
        heads_q <= heads_d;
        if (push_head) cur_route_q <= route_in;
      end
    end

    // Lock FSM: a head write locks (wins over a same-edge release); a tail
    // pop releases only if no later packet's head is still buffered, so a
    // VC holding A's tail and B's head stays locked across A's tail pop.
    always_ff @(posedge clk or negedge RST_) begin
      if (!RST_) lk_q <= LK_IDLE;
      else begin
        case (lk_q)
          LK_IDLE:   if (push_head) lk_q <= LK_LOCKED;
          LK_LOCKED: if (!push_head && pop_tail && heads_d == '0) lk_q <= LK_IDLE;
          default:   lk_q <= LK_IDLE;
        endcase
      end
    end
  end

endmodule
